msu_mem_arbiter: RTL and testbench
==================================

Name: msu_mem_arbiter

Overview:
- Shares one byte-wide external memory read port between two MSU requesters.
  - Data track channel: seek plus sequential byte reads, served from a prefetch FIFO.
  - Audio channel: single-byte fetches for the audio player.
- Sits between the MSU register block (data_addr/data_seek/data_req/data/data_ack) and the memory/DDR bridge.
- Audio has strict priority: it is real-time. Data prefetch uses the idle slots.

Parameters:
- DEPTH, 8: data prefetch FIFO depth in bytes; power of two, minimum 2.
- AW, 32: address width of all address ports.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- data_addr  in  AW  data track seek address; sampled when data_seek=1.
- data_seek  in  1  level/pulse; any cycle high starts a seek (flush plus refetch).
- data_req  in  1  one-cycle pulse; pop one byte from the FIFO.
- data  out  8  FIFO head byte.
- data_ack  out  1  level; 1 = data ready after seek.
- audio_addr  in  AW  audio byte address; sampled when audio_req=1.
- audio_req  in  1  one-cycle pulse; request one byte.
- audio_dout  out  8  fetched audio byte.
- audio_valid  out  1  one-cycle pulse; audio_dout valid.
- mem_addr  out  AW  memory read address.
- mem_rd  out  1  read request; held high until mem_ack.
- mem_din  in  8  memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle read completion.

Behaviour:
- Reset values:
  - Outputs: data=0, data_ack=0, audio_dout=0, audio_valid=0, mem_addr=0, mem_rd=0.
  - Internal: FIFO empty, fetch_addr=0, audio_pend=0, discard=0, armed=0, FSM=IDLE.
- FSM states:
  - IDLE, RD_AUDIO and RD_DATA.
  - In IDLE:
    - If audio_pend=1: mem_addr<=audio_addr_lat, mem_rd<=1, audio_pend<=0, go to RD_AUDIO.
    - Else if armed=1, no seek this cycle, and (fifo_count < DEPTH): mem_addr<=fetch_addr, mem_rd<=1, go to RD_DATA.
  - In RD_*: mem_rd and mem_addr are held stable until mem_ack. On mem_ack: mem_rd<=0, return to IDLE. Minimum one IDLE cycle between reads.
- Audio:
  - audio_req sets audio_pend and latches audio_addr.
  - A second audio_req while pending overwrites the latched address; the latest request wins and only one fetch is issued.
  - mem_ack in RD_AUDIO: audio_dout<=mem_din, audio_valid=1 for exactly the next cycle.
- Data seek (data_seek=1):
  - Flush the FIFO (count=0), fetch_addr<=data_addr, armed<=1, data_ack<=0.
  - If FSM is in RD_DATA: discard<=1. The in-flight byte is dropped at its mem_ack, discard clears, and no FIFO write or fetch_addr change occurs.
- Data fetch completion (RD_DATA, mem_ack, discard=0):
  - Push mem_din into the FIFO and increment fetch_addr. fetch_addr wraps modulo 2^AW.
  - data_ack<=1 on the first push after a seek; it stays 1 until the next seek.
- Pop:
  - data_req with count>0 advances the read pointer; data shows the new head the next cycle.
  - data_req with count=0 is ignored (underflow).
- FIFO full: no data fetch is issued. The in-flight fetch is guaranteed room because issue requires count<DEPTH, with no other in-flight data read.
- Simultaneous events:
  - Seek plus data_req in the same cycle: seek wins, pop ignored.
  - Seek plus data mem_ack in the same cycle: byte discarded.
  - Pop plus push on a full FIFO: both occur, count unchanged.
  - audio_req plus RD_AUDIO mem_ack in the same cycle: the old byte is delivered and the new request becomes pending.
- RESET mid-read:
  - mem_rd drops the next cycle.
  - A late mem_ack in IDLE with no outstanding read is ignored.
- Arithmetic: fifo_count is log2(DEPTH)+1 bits; read and write pointers are log2(DEPTH) bits and wrap naturally.

Optional Feature:
- Macro: MSU_DATA_UNDERFLOW_CNT_EN.
- When defined:
  - Adds output port data_underflow (16 bits).
  - It increments on every ignored data_req (count=0, no seek that cycle) and saturates at 0xFFFF.
  - It clears on RESET only.
- When undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Seek: data_addr=0x00001000, mem returns byte = addr[7:0] with a 3-cycle ack -> data_ack rises after the first push; data=0x00; 8 reads issued at 0x1000..0x1007, then no further mem_rd while full.
- Pop stream: after the previous scenario, 8 data_req pulses spaced 4 cycles -> data sequence 0x00..0x07; refetches continue at 0x1008 onward.
- Priority: audio_req addr=0x200000 while the FIFO is refilling -> the next IDLE issues mem_addr=0x200000 before any data fetch; audio_valid pulses once with audio_dout=0x00.
- Seek mid-flight: second seek to 0x00002050 while RD_DATA awaits ack -> the in-flight byte is dropped; the FIFO holds 0x50,0x51,... only; data_ack goes 0 then 1.
- Wrap: seek 0xFFFFFFFE -> fetch addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Underflow (with MSU_DATA_UNDERFLOW_CNT_EN): 3 data_req pulses on an empty FIFO before any seek -> data_underflow=3; no pointer movement; data unchanged.

Source files
------------

// File: rtl/msu_mem_arbiter.sv
// msu_mem_arbiter: shares one byte-wide memory read port between the MSU data
// track channel (seek + prefetch FIFO) and the audio channel (single bytes).
// Audio has strict priority; data prefetch uses the idle slots.
// Optional feature macro: MSU_DATA_UNDERFLOW_CNT_EN adds o_data_underflow, a
// saturating count of data_req pulses ignored because the FIFO was empty.
module msu_mem_arbiter #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_data_addr,
    input  logic          i_data_seek,
    input  logic          i_data_req,
    output logic [7:0]    o_data,
    output logic          o_data_ack,
    input  logic [AW-1:0] i_audio_addr,
    input  logic          i_audio_req,
    output logic [7:0]    o_audio_dout,
    output logic          o_audio_valid,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_rd,
    input  logic [7:0]    i_mem_din,
    input  logic          i_mem_ack
`ifdef MSU_DATA_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]   o_data_underflow
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRdAudio, StRdData} state_e;

    state_e        r_state, w_state_d;
    logic          w_issue_audio, w_issue_data, w_rd_done;
    logic          w_push, w_pop;

    logic [7:0]    r_fifo [DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_fetch_addr;
    logic          r_armed, r_discard, r_data_ack;

    logic          r_audio_pend;
    logic [AW-1:0] r_audio_addr_lat;
    logic [7:0]    r_audio_dout;
    logic          r_audio_valid;

    logic [AW-1:0] r_mem_addr;
    logic          r_mem_rd;

    // A byte landing while a seek is in flight (or was seen earlier) is stale.
    assign w_push = (r_state == StRdData) && i_mem_ack && !r_discard && !i_data_seek;
    assign w_pop  = i_data_req && !i_data_seek && (r_count != '0);

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= StIdle;
        else         r_state <= w_state_d;
    end

    // Next-state and issue decisions; audio pending always beats data prefetch
    always_comb begin
        w_state_d     = r_state;
        w_issue_audio = 1'b0;
        w_issue_data  = 1'b0;
        w_rd_done     = 1'b0;
        case (r_state)
            StIdle: begin
                if (r_audio_pend) begin
                    w_issue_audio = 1'b1;
                    w_state_d     = StRdAudio;
                end else if (r_armed && !i_data_seek && (r_count < FULL_CNT)) begin
                    w_issue_data = 1'b1;
                    w_state_d    = StRdData;
                end
            end
            StRdAudio, StRdData: begin
                if (i_mem_ack) begin
                    w_rd_done = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Memory request port: address/strobe held stable until the ack
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
        end else if (w_issue_audio) begin
            r_mem_addr <= r_audio_addr_lat;
            r_mem_rd   <= 1'b1;
        end else if (w_issue_data) begin
            r_mem_addr <= r_fetch_addr;
            r_mem_rd   <= 1'b1;
        end else if (w_rd_done) begin
            r_mem_rd   <= 1'b0;
        end
    end

    // Audio request latch and one-cycle result pulse; a new request wins over the clear
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_audio_pend     <= 1'b0;
            r_audio_addr_lat <= '0;
            r_audio_dout     <= '0;
            r_audio_valid    <= 1'b0;
        end else begin
            r_audio_valid <= (r_state == StRdAudio) && i_mem_ack;
            if ((r_state == StRdAudio) && i_mem_ack) r_audio_dout <= i_mem_din;
            if (w_issue_audio) r_audio_pend <= 1'b0;
            if (i_audio_req) begin
                r_audio_pend     <= 1'b1;
                r_audio_addr_lat <= i_audio_addr;
            end
        end
    end

    // Data seek, prefetch FIFO push/pop and fetch address tracking
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) r_fifo[i] <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_fetch_addr <= '0;
            r_armed      <= 1'b0;
            r_discard    <= 1'b0;
            r_data_ack   <= 1'b0;
        end else if (i_data_seek) begin
            // Flush keeps the read pointer so o_data does not glitch.
            r_wr_ptr     <= r_rd_ptr;
            r_count      <= '0;
            r_fetch_addr <= i_data_addr;
            r_armed      <= 1'b1;
            r_data_ack   <= 1'b0;
            // An ack in this same cycle already retires the stale read.
            r_discard    <= (r_state == StRdData) && !i_mem_ack;
        end else begin
            if ((r_state == StRdData) && i_mem_ack) r_discard <= 1'b0;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= i_mem_din;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
                r_fetch_addr     <= r_fetch_addr + AW'(1);
                r_data_ack       <= 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef MSU_DATA_UNDERFLOW_CNT_EN
    logic [15:0] r_underflow;

    // Saturating count of pops ignored on an empty FIFO
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_underflow <= '0;
        end else if (i_data_req && !i_data_seek && (r_count == '0)
                     && (r_underflow != 16'hFFFF)) begin
            r_underflow <= r_underflow + 16'd1;
        end
    end

    assign o_data_underflow = r_underflow;
`endif

    assign o_data        = r_fifo[r_rd_ptr];
    assign o_data_ack    = r_data_ack;
    assign o_audio_dout  = r_audio_dout;
    assign o_audio_valid = r_audio_valid;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_rd      = r_mem_rd;

endmodule

// File: tb/tb_msu_mem_arbiter.sv
// Bench for msu_mem_arbiter: queue-based reference model, bench-side memory
// responder, directed scenarios with literal expectations, then random traffic.
module tb_msu_mem_arbiter;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic [31:0] data_addr;
    logic        data_seek, data_req;
    logic [7:0]  data;
    logic        data_ack;
    logic [31:0] audio_addr;
    logic        audio_req;
    logic [7:0]  audio_dout;
    logic        audio_valid;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_din;
    logic        mem_ack;
`ifdef MSU_DATA_UNDERFLOW_CNT_EN
    logic [15:0] data_underflow;
`endif

    msu_mem_arbiter #(.DEPTH(DEPTH), .AW(32)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_data_addr  (data_addr),
        .i_data_seek  (data_seek),
        .i_data_req   (data_req),
        .o_data       (data),
        .o_data_ack   (data_ack),
        .i_audio_addr (audio_addr),
        .i_audio_req  (audio_req),
        .o_audio_dout (audio_dout),
        .o_audio_valid(audio_valid),
        .o_mem_addr   (mem_addr),
        .o_mem_rd     (mem_rd),
        .i_mem_din    (mem_din),
        .i_mem_ack    (mem_ack)
`ifdef MSU_DATA_UNDERFLOW_CNT_EN
        ,
        .o_data_underflow(data_underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  m_q[$];
    logic [31:0] m_fetch, m_alat, m_maddr;
    logic [7:0]  m_adout;
    bit          m_armed, m_discard, m_dack, m_pend, m_mrd, m_aval;
    int          m_busy;   // 0 none, 1 audio read outstanding, 2 data read outstanding
    int          m_uf;

    // Bench-side observation
    logic [31:0] issued[$];
    bit          prev_rd = 1'b0;
    int          aval_cnt = 0;
    logic [7:0]  last_adout = 8'h00;

    // Memory responder control
    int mem_wait = 0;
    int cur_lat = 1;
    int lat_fixed = 3;
    bit spur_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Next state of the model from its current state and the inputs about to be sampled
    task automatic model_next();
        bit issue_a, issue_d, a_done, d_done, push, pop, uf, seek_drop;
        int sz;
        if (rst) begin
            m_q.delete();
            m_fetch = '0; m_alat = '0; m_maddr = '0; m_adout = '0;
            m_armed = 0; m_discard = 0; m_dack = 0; m_pend = 0; m_mrd = 0; m_aval = 0;
            m_busy = 0; m_uf = 0;
            return;
        end
        sz        = m_q.size();
        issue_a   = (m_busy == 0) && m_pend;
        issue_d   = (m_busy == 0) && !m_pend && m_armed && !data_seek && (sz < DEPTH);
        a_done    = (m_busy == 1) && mem_ack;
        d_done    = (m_busy == 2) && mem_ack;
        seek_drop = (m_busy == 2) && !mem_ack;
        push      = d_done && !m_discard && !data_seek;
        pop       = data_req && !data_seek && (sz > 0);
        uf        = data_req && !data_seek && (sz == 0);

        if (issue_a) begin
            m_mrd = 1; m_maddr = m_alat; m_busy = 1;
        end else if (issue_d) begin
            m_mrd = 1; m_maddr = m_fetch; m_busy = 2;
        end else if (a_done || d_done) begin
            m_mrd = 0; m_busy = 0;
        end

        m_aval = a_done;
        if (a_done) m_adout = mem_din;
        if (issue_a) m_pend = 0;
        if (audio_req) begin
            m_pend = 1; m_alat = audio_addr;
        end

        if (data_seek) begin
            m_q.delete();
            m_fetch = data_addr; m_armed = 1; m_dack = 0; m_discard = seek_drop;
        end else begin
            if (d_done) m_discard = 0;
            if (pop) m_q.delete(0);
            if (push) begin
                m_q.push_back(mem_din);
                m_fetch = m_fetch + 32'd1;
                m_dack = 1;
            end
        end
        if (uf && m_uf < 65535) m_uf++;
    endtask

    task automatic compare();
        chk("mem_rd", mem_rd, m_mrd);
        chk("mem_addr", mem_addr, m_maddr);
        chk("audio_valid", audio_valid, m_aval);
        chk("audio_dout", audio_dout, m_adout);
        chk("data_ack", data_ack, m_dack);
        if (m_q.size() > 0) chk("data_head", data, m_q[0]);
`ifdef MSU_DATA_UNDERFLOW_CNT_EN
        chk("data_underflow", data_underflow, m_uf);
`endif
        if (mem_rd && !prev_rd) issued.push_back(mem_addr);
        prev_rd = mem_rd;
        if (audio_valid) begin
            aval_cnt++;
            last_adout = audio_dout;
        end
    endtask

    // Memory returns byte = addr[7:0] after the configured latency
    task automatic mem_respond();
        if (mem_rd) begin
            if (mem_wait == 0) cur_lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
            mem_wait++;
            if (mem_wait >= cur_lat) begin
                mem_ack  = 1'b1;
                mem_din  = mem_addr[7:0];
                mem_wait = 0;
            end else begin
                mem_ack  = 1'b0;
                mem_din  = 8'($urandom);
            end
        end else begin
            mem_wait = 0;
            mem_ack  = spur_en && ($urandom_range(0, 15) == 0);
            mem_din  = 8'($urandom);
        end
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
        compare();
        rst = 1'b0; data_seek = 1'b0; data_req = 1'b0; audio_req = 1'b0;
        mem_respond();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_full(input string name);
        int n = 0;
        while (m_q.size() < DEPTH && n < 300) begin
            tick();
            n++;
        end
        chk(name, m_q.size(), DEPTH);
    endtask

    task automatic wait_mem_rd(input string name);
        int n = 0;
        while (!mem_rd && n < 50) begin
            tick();
            n++;
        end
        chk(name, mem_rd, 1);
    endtask

    initial begin
        rst = 1'b1; data_addr = '0; data_seek = 0; data_req = 0;
        audio_addr = '0; audio_req = 0; mem_din = '0; mem_ack = 0;

        // Reset
        rst = 1'b1; tick();
        rst = 1'b1; tick();
        chk("rst_data", data, 8'h00);
        chk("rst_data_ack", data_ack, 0);
        chk("rst_audio_dout", audio_dout, 8'h00);
        chk("rst_audio_valid", audio_valid, 0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_rd", mem_rd, 0);

        // Underflow before any seek
        for (int i = 0; i < 3; i++) begin
            data_req = 1'b1; tick(); tick();
        end
        chk("uf_data", data, 8'h00);
        chk("uf_no_fetch", mem_rd, 0);
`ifdef MSU_DATA_UNDERFLOW_CNT_EN
        chk("uf_count", data_underflow, 16'd3);
`endif

        // Seek to 0x1000, fill the FIFO, then no more reads while full
        issued.delete();
        data_addr = 32'h0000_1000; data_seek = 1'b1; tick();
        chk("seek_ack_low", data_ack, 0);
        wait_full("seek_fill");
        ticks(20);
        chk("seek_issue_cnt", issued.size(), 8);
        for (int i = 0; i < 8 && i < issued.size(); i++)
            chk("seek_issue_addr", issued[i], 32'h0000_1000 + i);
        chk("seek_data", data, 8'h00);
        chk("seek_ack_high", data_ack, 1);

        // Pop stream
        issued.delete();
        for (int i = 0; i < 8; i++) begin
            chk("pop_data", data, i);
            data_req = 1'b1; tick();
            ticks(3);
        end
        chk("refetch_seen", issued.size() > 0, 1);
        if (issued.size() > 0) chk("refetch_addr", issued[0], 32'h0000_1008);

        // Audio priority while refilling
        wait_full("prio_prefill");
        data_req = 1'b1; tick();
        data_req = 1'b1; tick();
        wait_mem_rd("prio_data_rd");
        aval_cnt = 0;
        audio_addr = 32'h0020_0000; audio_req = 1'b1; tick();
        issued.delete();
        ticks(20);
        chk("prio_issued", issued.size() > 0, 1);
        if (issued.size() > 0) chk("prio_first_addr", issued[0], 32'h0020_0000);
        chk("prio_valid_cnt", aval_cnt, 1);
        chk("prio_dout", last_adout, 8'h00);

        // Seek while a data read is outstanding
        wait_full("mid_prefill");
        data_req = 1'b1; tick();
        wait_mem_rd("mid_data_rd");
        data_addr = 32'h0000_2050; data_seek = 1'b1; tick();
        chk("mid_ack_low", data_ack, 0);
        wait_full("mid_fill");
        chk("mid_ack_high", data_ack, 1);
        for (int i = 0; i < 3; i++) begin
            chk("mid_data", data, 8'h50 + i);
            data_req = 1'b1; tick();
            ticks(2);
        end

        // Address wrap
        issued.delete();
        data_addr = 32'hFFFF_FFFE; data_seek = 1'b1; tick();
        ticks(40);
        chk("wrap_issued", issued.size() >= 3, 1);
        if (issued.size() >= 3) begin
            chk("wrap_a0", issued[0], 32'hFFFF_FFFE);
            chk("wrap_a1", issued[1], 32'hFFFF_FFFF);
            chk("wrap_a2", issued[2], 32'h0000_0000);
        end

        // Random traffic with random latency, stray acks and resets
        lat_fixed = 0;
        spur_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) begin
                data_seek = 1'b1;
                data_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                                         : $urandom;
            end
            data_req = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 11) == 0) begin
                audio_req = 1'b1;
                audio_addr = $urandom;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
